maze_player_engine: RTL and testbench
=====================================

Name: maze_player_engine

Overview:
- Frame-rate player motion and collision engine for the tilt-maze game.
- Owns the player box position, the lives counter and the game state (idle, play, hit, win, game-over).
- Checks walls sequentially, one cell index per pixel clock, so the grid size can be scaled without a wide combinational compare.
- Sits between the tilt decoder / LFSR wall generator and the VGA pixel mux, which draws the box from pos_x/pos_y.

Parameters:
- COLS, 5, maze columns
- ROWS, 5, maze rows
- CELL, 80, cell pitch in pixels
- WALL_T, 2, wall thickness in pixels
- X0, 120, playfield left pixel
- Y0, 0, playfield top pixel
- PSIZE, 20, player box side in pixels
- START_X, 130, spawn box left pixel
- START_Y, 330, spawn box top pixel
- GOAL_C, 4, goal cell column
- GOAL_R, 0, goal cell row
- MAX_SPEED, 4, per-frame velocity clamp in pixels
- TILT_W, 5, tilt input width (two's complement)
- LIVES, 3, lives granted at start
- HIT_FRAMES, 30, frames the player stays frozen after a hit

Ports:
- pixel_clk  in  1  pixel clock
- reset  in  1  asynchronous active-high reset
- frame_tick  in  1  one-cycle pulse, once per frame, during vertical blank
- move_en  in  1  motion enable
- start  in  1  one-cycle pulse; begins or restarts a game
- respawn  in  1  one-cycle pulse; returns the player to spawn
- tilt_x  in  TILT_W  signed x velocity request
- tilt_y  in  TILT_W  signed y velocity request
- hwall  in  COLS*ROWS  bit r*COLS+c set = wall on the bottom edge of cell (c,r)
- vwall  in  COLS*ROWS  bit r*COLS+c set = wall on the right edge of cell (c,r)
- pos_x  out  11  player box left pixel
- pos_y  out  11  player box top pixel
- state  out  3  game state code
- lives  out  $clog2(LIVES+1)  remaining lives
- hit_pulse  out  1  one-cycle pulse on a collision
- win_pulse  out  1  one-cycle pulse on reaching the goal
- busy  out  1  high while a scan is in progress
- overrun  out  1  sticky; set when frame_tick arrives while busy

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high; ports are named pixel_clk and reset.
- Reset values: pos = (START_X, START_Y); state = IDLE; lives = LIVES; all pulses, busy and overrun = 0.
- Geometry:
  - Player box is inclusive [pos, pos+PSIZE-1] on each axis.
  - hwall(c,r) rectangle: x [X0+c*CELL, X0+(c+1)*CELL-1], y [Y0+(r+1)*CELL-WALL_T, Y0+(r+1)*CELL-1].
  - vwall(c,r) rectangle: x [X0+(c+1)*CELL-WALL_T, X0+(c+1)*CELL-1], y [Y0+r*CELL, Y0+(r+1)*CELL-1].
  - The outer border is always solid, WALL_T thick, inside the playfield extent.
  - Overlap tests use inclusive bounds on both axes.
- Velocity:
  - vel = clamp(tilt, -MAX_SPEED, +MAX_SPEED), per axis.
  - vel = 0 when move_en = 0.
  - The candidate position is computed in 12-bit signed arithmetic. A negative candidate, or one beyond 2047, counts as a border collision.
- FSM:
  - IDLE: on start, go to PLAY with pos = spawn and lives = LIVES.
  - PLAY: on frame_tick, latch cand = pos + vel, set k = 0, assert busy, go to SCAN.
  - SCAN: each cycle test hwall[k] and vwall[k] against cand, and OR the results into a hit flag. k = 0 also tests the border. After k = COLS*ROWS-1, go to COMMIT. Scan latency is COLS*ROWS cycles.
  - COMMIT (1 cycle), deassert busy, then apply the first matching case:
    - respawn pending: pos = spawn, go to PLAY.
    - hit: pos = spawn, pulse hit_pulse, lives-1. If lives becomes 0, go to OVER; else go to HIT.
    - cand fully inside the goal cell interior: pos = cand, pulse win_pulse, go to WIN.
    - otherwise: pos = cand, go to PLAY.
  - HIT: count HIT_FRAMES frame_ticks, then go to PLAY. Position is frozen.
  - WIN / OVER: position is frozen; start goes to PLAY with a full reset of pos and lives.
- Boundaries and simultaneous events:
  - Collision takes priority over win.
  - frame_tick while busy: ignored, and sets overrun (cleared only by reset or start).
  - respawn in PLAY, HIT, WIN or OVER: applied immediately. During SCAN it is latched and applied at COMMIT.
  - start in PLAY, SCAN or HIT: ignored.
  - lives saturate at 0 and never wrap.
  - Reset asserted mid-SCAN aborts the scan; no pulse is issued.
  - pos outputs change only at COMMIT, on respawn/start, or at reset.

Decomposition:
- maze_pkg holds the state encoding (IDLE=0, PLAY=1, SCAN=2, COMMIT=3, HIT=4, WIN=5, OVER=6), the wall-rectangle bound constants, and the clamp function.
- One natural sub-module, maze_wall_rect: combinational. Takes (k, cand_x, cand_y) and returns the h-overlap and v-overlap flags, so the SCAN datapath is a single instance indexed by k.

Test Plan:
- Reset, start, tilt (+3,0), no walls, 3 frame_ticks -> pos_x = 139, pos_y = 330, no hit_pulse; busy high exactly 25 cycles per tick.
- tilt_x = +15 -> clamped: pos_x advances by 4 per frame.
- vwall[20] = 1 (right edge of cell (0,4) at x = 198..199), tilt_x = +4 from pos_x = 178 -> candidate 182..201 overlaps -> hit_pulse, pos = (130,330), lives = 2, state = HIT for 30 ticks, then PLAY.
- Three hits -> lives = 0, state = OVER; further ticks leave pos unchanged; start -> PLAY, lives = 3.
- Player steered into goal cell (4,0) interior with no walls -> single win_pulse, state = WIN, pos frozen.
- frame_tick reasserted 10 cycles after the previous one -> overrun = 1, second tick ignored; respawn pulsed mid-SCAN -> pos = spawn at COMMIT, no hit_pulse.

Source files
------------

// File: rtl/maze_pkg.sv
// maze_pkg: shared constants, state encoding and helpers for the tilt-maze
// player engine.
// Holds the maze geometry, the derived legal-position bounds for the player
// box, the FSM state codes and the per-axis velocity clamp.
package maze_pkg;

  localparam int COLS       = 5;
  localparam int ROWS       = 5;
  localparam int CELL       = 80;
  localparam int WALL_T     = 2;
  localparam int X0         = 120;
  localparam int Y0         = 0;
  localparam int PSIZE      = 20;
  localparam int START_X    = 130;
  localparam int START_Y    = 330;
  localparam int GOAL_C     = 4;
  localparam int GOAL_R     = 0;
  localparam int MAX_SPEED  = 4;
  localparam int TILT_W     = 5;
  localparam int LIVES      = 3;
  localparam int HIT_FRAMES = 30;

  localparam int NCELL   = COLS * ROWS;
  localparam int K_W     = $clog2(NCELL);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int HCNT_W  = $clog2(HIT_FRAMES);

  // Legal range of the box's left/top pixel so that the whole box stays
  // clear of the solid outer border.
  localparam int BX_MIN = X0 + WALL_T;
  localparam int BX_MAX = X0 + COLS * CELL - WALL_T - PSIZE;
  localparam int BY_MIN = Y0 + WALL_T;
  localparam int BY_MAX = Y0 + ROWS * CELL - WALL_T - PSIZE;

  // Range of the box's left/top pixel for the box to lie fully inside the
  // goal cell interior (cell shrunk by one wall thickness on every side).
  localparam int GX_MIN = X0 + GOAL_C * CELL + WALL_T;
  localparam int GX_MAX = X0 + (GOAL_C + 1) * CELL - WALL_T - PSIZE;
  localparam int GY_MIN = Y0 + GOAL_R * CELL + WALL_T;
  localparam int GY_MAX = Y0 + (GOAL_R + 1) * CELL - WALL_T - PSIZE;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PLAY   = 3'd1,
    ST_SCAN   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_HIT    = 3'd4,
    ST_WIN    = 3'd5,
    ST_OVER   = 3'd6
  } state_t;

  // Clamp a signed tilt request to +/-MAX_SPEED, widened to 12-bit signed.
  function automatic logic signed [11:0] clamp_vel(input logic signed [TILT_W-1:0] t);
    int v;
    v = int'(t);
    if (v > MAX_SPEED) begin
      v = MAX_SPEED;
    end else if (v < -MAX_SPEED) begin
      v = -MAX_SPEED;
    end
    return 12'(v);
  endfunction

endpackage

// File: rtl/maze_wall_rect.sv
// maze_wall_rect: combinational overlap test of the candidate player box
// against the bottom-edge (h) and right-edge (v) wall rectangles of cell k.
// Ports:
//   i_k       cell index, k = r*COLS + c
//   i_cand_x  candidate box left pixel (12-bit signed)
//   i_cand_y  candidate box top pixel (12-bit signed)
//   o_h_ovl   box overlaps the bottom-edge wall rectangle of cell k
//   o_v_ovl   box overlaps the right-edge wall rectangle of cell k
// The wall enables are applied by the caller; this block is pure geometry.
module maze_wall_rect
  import maze_pkg::*;
(
  input  logic [K_W-1:0]     i_k,
  input  logic signed [11:0] i_cand_x,
  input  logic signed [11:0] i_cand_y,
  output logic               o_h_ovl,
  output logic               o_v_ovl
);

  always_comb begin
    int c;
    int r;
    int bx;
    int by;
    c  = int'(i_k) % COLS;
    r  = int'(i_k) / COLS;
    bx = int'(i_cand_x);
    by = int'(i_cand_y);
    // Inclusive interval overlap: box [b, b+PSIZE-1] vs wall [lo, hi].
    o_h_ovl = (bx <= X0 + (c + 1) * CELL - 1) &&
              (bx + PSIZE - 1 >= X0 + c * CELL) &&
              (by <= Y0 + (r + 1) * CELL - 1) &&
              (by + PSIZE - 1 >= Y0 + (r + 1) * CELL - WALL_T);
    o_v_ovl = (bx <= X0 + (c + 1) * CELL - 1) &&
              (bx + PSIZE - 1 >= X0 + (c + 1) * CELL - WALL_T) &&
              (by <= Y0 + (r + 1) * CELL - 1) &&
              (by + PSIZE - 1 >= Y0 + r * CELL);
  end

endmodule

// File: rtl/maze_player_engine.sv
// maze_player_engine: frame-rate player motion and collision engine.
// Owns the player box position, lives and game state. On each frame_tick in
// PLAY it latches a candidate position and scans one wall cell per clock,
// then commits the move, a hit, or a win.
// Ports:
//   pixel_clk, reset         clock and asynchronous active-high reset
//   frame_tick               once-per-frame pulse (vertical blank)
//   move_en                  motion enable; velocity forced to 0 when low
//   start, respawn           one-cycle game control pulses
//   tilt_x, tilt_y           signed velocity requests
//   hwall, vwall             per-cell bottom / right wall enables
//   pos_x, pos_y             player box top-left pixel
//   state                    game state code (see maze_pkg::state_t)
//   lives                    remaining lives
//   hit_pulse, win_pulse     one-cycle event pulses
//   busy                     high during the wall scan
//   overrun                  sticky: frame_tick arrived during a scan
module maze_player_engine
  import maze_pkg::*;
(
  input  logic                     pixel_clk,
  input  logic                     reset,
  input  logic                     frame_tick,
  input  logic                     move_en,
  input  logic                     start,
  input  logic                     respawn,
  input  logic signed [TILT_W-1:0] tilt_x,
  input  logic signed [TILT_W-1:0] tilt_y,
  input  logic [NCELL-1:0]         hwall,
  input  logic [NCELL-1:0]         vwall,
  output logic [10:0]              pos_x,
  output logic [10:0]              pos_y,
  output logic [2:0]               state,
  output logic [LIVES_W-1:0]       lives,
  output logic                     hit_pulse,
  output logic                     win_pulse,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [10:0]         SPAWN_X    = 11'(START_X);
  localparam logic [10:0]         SPAWN_Y    = 11'(START_Y);
  localparam logic [LIVES_W-1:0]  LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [K_W-1:0]      K_LAST     = K_W'(NCELL - 1);
  localparam logic [HCNT_W-1:0]   HCNT_LAST  = HCNT_W'(HIT_FRAMES - 1);

  state_t              r_state;
  logic [10:0]         r_pos_x, r_pos_y;
  logic signed [11:0]  r_cand_x, r_cand_y;
  logic [K_W-1:0]      r_k;
  logic                r_hit;
  logic                r_resp_pend;
  logic [LIVES_W-1:0]  r_lives;
  logic [HCNT_W-1:0]   r_hcnt;
  logic                r_hit_pulse, r_win_pulse, r_busy, r_overrun;

  logic signed [11:0]  w_vel_x, w_vel_y;
  logic                w_h_ovl, w_v_ovl;
  logic                w_border, w_goal, w_scan_hit;

  assign w_vel_x = move_en ? clamp_vel(tilt_x) : 12'sd0;
  assign w_vel_y = move_en ? clamp_vel(tilt_y) : 12'sd0;

  maze_wall_rect u_wall_rect (
    .i_k      (r_k),
    .i_cand_x (r_cand_x),
    .i_cand_y (r_cand_y),
    .o_h_ovl  (w_h_ovl),
    .o_v_ovl  (w_v_ovl)
  );

  // A candidate beyond 2047 wraps negative in 12-bit signed, so the sign bit
  // covers both off-range cases. The range test also rejects any box that
  // would touch or cross the solid outer border.
  always_comb begin
    w_border = r_cand_x[11] || r_cand_y[11] ||
               (int'(r_cand_x) < BX_MIN) || (int'(r_cand_x) > BX_MAX) ||
               (int'(r_cand_y) < BY_MIN) || (int'(r_cand_y) > BY_MAX);
    w_goal   = (int'(r_cand_x) >= GX_MIN) && (int'(r_cand_x) <= GX_MAX) &&
               (int'(r_cand_y) >= GY_MIN) && (int'(r_cand_y) <= GY_MAX);
  end

  assign w_scan_hit = (hwall[r_k] & w_h_ovl) | (vwall[r_k] & w_v_ovl) |
                      ((r_k == K_W'(0)) & w_border);

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pos_x     <= SPAWN_X;
      r_pos_y     <= SPAWN_Y;
      r_cand_x    <= '0;
      r_cand_y    <= '0;
      r_k         <= '0;
      r_hit       <= 1'b0;
      r_resp_pend <= 1'b0;
      r_lives     <= LIVES_INIT;
      r_hcnt      <= '0;
      r_hit_pulse <= 1'b0;
      r_win_pulse <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_hit_pulse <= 1'b0;
      r_win_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pos_x   <= SPAWN_X;
            r_pos_y   <= SPAWN_Y;
            r_lives   <= LIVES_INIT;
            r_overrun <= 1'b0;
            r_state   <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          // A respawn in the same cycle as a tick wins; that frame is skipped.
          if (respawn) begin
            r_pos_x <= SPAWN_X;
            r_pos_y <= SPAWN_Y;
          end else if (frame_tick) begin
            r_cand_x    <= $signed({1'b0, r_pos_x}) + w_vel_x;
            r_cand_y    <= $signed({1'b0, r_pos_y}) + w_vel_y;
            r_k         <= '0;
            r_hit       <= 1'b0;
            r_resp_pend <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          r_hit <= r_hit | w_scan_hit;
          if (frame_tick) r_overrun <= 1'b1;
          if (respawn) r_resp_pend <= 1'b1;
          if (r_k == K_LAST) begin
            r_busy  <= 1'b0;
            r_state <= ST_COMMIT;
          end else begin
            r_k <= r_k + K_W'(1);
          end
        end
        ST_COMMIT: begin
          if (r_resp_pend || respawn) begin
            r_pos_x <= SPAWN_X;
            r_pos_y <= SPAWN_Y;
            r_state <= ST_PLAY;
          end else if (r_hit) begin
            r_pos_x     <= SPAWN_X;
            r_pos_y     <= SPAWN_Y;
            r_hit_pulse <= 1'b1;
            r_hcnt      <= '0;
            r_lives     <= (r_lives == '0) ? '0 : r_lives - LIVES_W'(1);
            r_state     <= (r_lives <= LIVES_W'(1)) ? ST_OVER : ST_HIT;
          end else if (w_goal) begin
            r_pos_x     <= r_cand_x[10:0];
            r_pos_y     <= r_cand_y[10:0];
            r_win_pulse <= 1'b1;
            r_state     <= ST_WIN;
          end else begin
            r_pos_x <= r_cand_x[10:0];
            r_pos_y <= r_cand_y[10:0];
            r_state <= ST_PLAY;
          end
        end
        ST_HIT: begin
          if (respawn) begin
            r_pos_x <= SPAWN_X;
            r_pos_y <= SPAWN_Y;
          end
          if (frame_tick) begin
            if (r_hcnt == HCNT_LAST) begin
              r_state <= ST_PLAY;
            end else begin
              r_hcnt <= r_hcnt + HCNT_W'(1);
            end
          end
        end
        ST_WIN, ST_OVER: begin
          if (start) begin
            r_pos_x   <= SPAWN_X;
            r_pos_y   <= SPAWN_Y;
            r_lives   <= LIVES_INIT;
            r_overrun <= 1'b0;
            r_state   <= ST_PLAY;
          end else if (respawn) begin
            r_pos_x <= SPAWN_X;
            r_pos_y <= SPAWN_Y;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pos_x     = r_pos_x;
  assign pos_y     = r_pos_y;
  assign state     = r_state;
  assign lives     = r_lives;
  assign hit_pulse = r_hit_pulse;
  assign win_pulse = r_win_pulse;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_maze_player_engine.sv
// tb_maze_player_engine: directed self-checking bench for maze_player_engine.
// Walks through motion, clamping, wall/border hits, lives exhaustion, a win,
// overrun, respawn during a scan and reset during a scan, with every expected
// value worked out by hand from the maze geometry.
module tb_maze_player_engine;
  import maze_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0, move_en = 1'b0, start = 1'b0, respawn = 1'b0;
  logic signed [TILT_W-1:0] tilt_x = '0, tilt_y = '0;
  logic [NCELL-1:0] hwall = '0, vwall = '0;
  logic [10:0] pos_x, pos_y;
  logic [2:0] state;
  logic [LIVES_W-1:0] lives;
  logic hit_pulse, win_pulse, busy, overrun;

  int n_checks = 0;
  int n_fail = 0;
  int frame_no = 0;
  int hit_cnt = 0;
  int win_cnt = 0;
  int bc;
  bit h, w;

  always #5 clk = ~clk;

  maze_player_engine dut (
    .pixel_clk  (clk),
    .reset      (rst),
    .frame_tick (frame_tick),
    .move_en    (move_en),
    .start      (start),
    .respawn    (respawn),
    .tilt_x     (tilt_x),
    .tilt_y     (tilt_y),
    .hwall      (hwall),
    .vwall      (vwall),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .state      (state),
    .lives      (lives),
    .hit_pulse  (hit_pulse),
    .win_pulse  (win_pulse),
    .busy       (busy),
    .overrun    (overrun)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_respawn();
    @(negedge clk); respawn = 1'b1;
    @(negedge clk); respawn = 1'b0;
  endtask

  // One frame: tick, then watch 32 cycles (scan + commit + pulse fit in 28).
  task automatic frame(output int bc_o, output bit h_o, output bit w_o);
    bc_o = 0; h_o = 1'b0; w_o = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (busy) bc_o++;
      if (hit_pulse) h_o = 1'b1;
      if (win_pulse) w_o = 1'b1;
    end
    frame_no++;
    if (h_o) hit_cnt++;
    if (w_o) win_cnt++;
    $display("frame %0d pos=(%0d,%0d) state=%0d lives=%0d busy_cycles=%0d hit=%0d win=%0d",
             frame_no, pos_x, pos_y, state, lives, bc_o, h_o, w_o);
  endtask

  task automatic frames(input int n, input int tx, input int ty);
    int b;
    bit hh, ww;
    tilt_x = TILT_W'(tx);
    tilt_y = TILT_W'(ty);
    for (int i = 0; i < n; i++) frame(b, hh, ww);
  endtask

  // Bare frame ticks, used while frozen in HIT.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_pos_x", pos_x, 130);
    check("rst_pos_y", pos_y, 330);
    check("rst_state", state, 0);
    check("rst_lives", lives, 3);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_pulses", {hit_pulse, win_pulse}, 0);
    rst = 1'b0;
    move_en = 1'b1;

    pulse_start();
    check("start_state", state, 1);
    check("start_lives", lives, 3);

    // Plain motion, no walls: 130 + 3*3 = 139.
    tilt_x = 5'sd3; tilt_y = 5'sd0;
    for (int i = 0; i < 3; i++) begin
      frame(bc, h, w);
      check("busy_cycles", bc, 25);
      check("move_no_hit", h, 0);
    end
    check("move_pos_x", pos_x, 139);
    check("move_pos_y", pos_y, 330);

    frames(1, 15, 0);
    check("clamp_pos", pos_x, 143);
    frames(1, -16, 0);
    check("clamp_neg", pos_x, 139);
    move_en = 1'b0;
    frames(1, 4, 4);
    check("move_en_off_x", pos_x, 139);
    check("move_en_off_y", pos_y, 330);
    move_en = 1'b1;

    pulse_respawn();
    check("respawn_play_x", pos_x, 130);
    check("respawn_play_state", state, 1);

    // 12 frames of +4 -> 178, then cand 182..201 hits vwall(0,4) at 198..199.
    hit_cnt = 0;
    frames(12, 4, 0);
    check("pre_hit_x", pos_x, 178);
    check("pre_hit_cnt", hit_cnt, 0);
    vwall[20] = 1'b1;
    frames(1, 4, 0);
    check("hit1_pulse", hit_cnt, 1);
    check("hit1_pos_x", pos_x, 130);
    check("hit1_pos_y", pos_y, 330);
    check("hit1_lives", lives, 2);
    check("hit1_state", state, 4);
    ticks(29);
    check("hit_hold_state", state, 4);
    check("hit_hold_pos", pos_x, 130);
    ticks(1);
    check("hit_release", state, 1);

    // Left border at 120..121: cands 126, 122 clear, 118 hits.
    frames(2, -4, 0);
    check("border_clear_x", pos_x, 122);
    check("border_clear_cnt", hit_cnt, 1);
    frames(1, -4, 0);
    check("hit2_pulse", hit_cnt, 2);
    check("hit2_lives", lives, 1);
    check("hit2_state", state, 4);
    check("hit2_pos_x", pos_x, 130);
    ticks(30);
    check("hit2_release", state, 1);

    // hwall(0,3) at y 318..319: cands 326, 322 clear, 318 hits.
    hwall[15] = 1'b1;
    frames(2, 0, -4);
    check("hwall_clear_y", pos_y, 322);
    frames(1, 0, -4);
    check("hit3_pulse", hit_cnt, 3);
    check("hit3_lives", lives, 0);
    check("over_state", state, 6);
    check("hit3_pos_y", pos_y, 330);
    frame(bc, h, w);
    check("over_frozen_x", pos_x, 130);
    check("over_no_scan", bc, 0);
    check("over_state_hold", state, 6);
    check("over_lives_sat", lives, 0);
    pulse_start();
    check("restart_state", state, 1);
    check("restart_lives", lives, 3);

    // Steer to the goal cell: 68 diagonal frames -> (402,58), then +4 in x;
    // the box first fits the goal interior at x = 442.
    hwall = '0; vwall = '0;
    win_cnt = 0;
    frames(68, 4, -4);
    check("diag_x", pos_x, 402);
    check("diag_y", pos_y, 58);
    frames(9, 4, 0);
    check("pre_win_x", pos_x, 438);
    check("pre_win_cnt", win_cnt, 0);
    frames(1, 4, 0);
    check("win_pulse", win_cnt, 1);
    check("win_pos_x", pos_x, 442);
    check("win_state", state, 5);
    frames(1, 4, 0);
    check("win_frozen_x", pos_x, 442);
    check("win_single", win_cnt, 1);
    pulse_respawn();
    check("respawn_win_x", pos_x, 130);
    check("respawn_win_y", pos_y, 330);
    check("respawn_win_state", state, 5);
    pulse_start();
    check("start_win_state", state, 1);
    check("start_overrun_clr", overrun, 0);

    // Second tick 10 cycles in, respawn mid-scan.
    tilt_x = 5'sd4; tilt_y = 5'sd0;
    bc = 0; h = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      frame_tick = (i == 0) || (i == 10);
      respawn = (i == 15);
      if (busy) bc++;
      if (hit_pulse) h = 1'b1;
    end
    frame_tick = 1'b0; respawn = 1'b0;
    $display("overrun transaction pos=(%0d,%0d) busy_cycles=%0d overrun=%0d", pos_x, pos_y, bc, overrun);
    check("ovr_busy_cycles", bc, 25);
    check("ovr_flag", overrun, 1);
    check("ovr_respawn_x", pos_x, 130);
    check("ovr_no_hit", h, 0);
    check("ovr_state", state, 1);
    pulse_start();
    check("start_play_ignored_ovr", overrun, 1);
    check("start_play_ignored_st", state, 1);

    // Reset in the middle of a scan that would have moved to 134.
    h = 1'b0; w = 1'b0;
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hit_pulse) h = 1'b1;
      if (win_pulse) w = 1'b1;
    end
    $display("reset_mid_scan pos=(%0d,%0d) state=%0d busy=%0d", pos_x, pos_y, state, busy);
    check("rst_scan_state", state, 0);
    check("rst_scan_busy", busy, 0);
    check("rst_scan_overrun", overrun, 0);
    check("rst_scan_pos_x", pos_x, 130);
    check("rst_scan_pulses", {h, w}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
